// File: rtl/conv_pkg.sv
// Shared definitions for the 3-tap convolution PE array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, pixel/product widths, default layer geometry,
//           and a counter-width helper that never returns zero.
package conv_pkg;

  localparam int PIX_W  = 8;   // IFM pixel and weight width
  localparam int PROD_W = 16;  // full-precision product width
  localparam int CH_W   = 6;   // channel index width (up to 64 channels)

  localparam int DEF_NUM_CH        = 32;
  localparam int DEF_GROUPS_PER_CH = 2048;
  localparam int DEF_DONE2_DLY     = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE_WAIT
  } conv_state_t;

  // Width of a counter that must hold 0..n-1; at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_pe_array_pe_mac3.sv
// Single 3-tap multiply-accumulate: sum = (x0*w0 + x1*w1 + x2*w2) mod 2^PIX_W.
// Latency: 2 cycles (products registered, then truncated sum registered).
// Backpressure: none; stages load only when their valid is high, otherwise hold.
// Ports: clk, rstn (async active-low), in_vld (load stage 1), s1_vld (load
//        stage 2), x0..x2 pixels, w0..w2 weights, sum (registered result).
module pe_mac3
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  input  logic             s1_vld,
  input  logic [PIX_W-1:0] x0,
  input  logic [PIX_W-1:0] x1,
  input  logic [PIX_W-1:0] x2,
  input  logic [PIX_W-1:0] w0,
  input  logic [PIX_W-1:0] w1,
  input  logic [PIX_W-1:0] w2,
  output logic [PIX_W-1:0] sum
);

  logic [PROD_W-1:0] p0_q, p1_q, p2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      sum  <= '0;
    end else begin
      if (in_vld) begin
        p0_q <= PROD_W'(x0) * PROD_W'(w0);
        p1_q <= PROD_W'(x1) * PROD_W'(w1);
        p2_q <= PROD_W'(x2) * PROD_W'(w2);
      end
      // Only the low byte of the 16-bit sum leaves the MAC.
      if (s1_vld) begin
        sum <= PIX_W'(p0_q + p1_q + p2_q);
      end
    end
  end

endmodule

// File: rtl/conv_pe_array.sv
// Convolution PE array: five 3-tap MACs over a 7-pixel IFM group, with layer
//   sequencing (group/channel counters) and OFM readout handshake pulses.
// Latency: accepted group at cycle t gives pe_sum_valid at t+2.
// Backpressure: in_ready high only in RUN; in_valid low inserts bubbles.
// Ports: clk, rstn, start, in_valid/in_ready, ifm_0..6, w_0..2 in;
//        pe_sum_1..5, pe_sum_valid, c_i_c, conv_done, conv_done_1/2 out.
module conv_pe_array
  import conv_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int GROUPS_PER_CH = DEF_GROUPS_PER_CH,
  parameter int DONE2_DLY     = DEF_DONE2_DLY
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] ifm_0,
  input  logic [PIX_W-1:0] ifm_1,
  input  logic [PIX_W-1:0] ifm_2,
  input  logic [PIX_W-1:0] ifm_3,
  input  logic [PIX_W-1:0] ifm_4,
  input  logic [PIX_W-1:0] ifm_5,
  input  logic [PIX_W-1:0] ifm_6,
  input  logic [PIX_W-1:0] w_0,
  input  logic [PIX_W-1:0] w_1,
  input  logic [PIX_W-1:0] w_2,
  output logic [PIX_W-1:0] pe_sum_1,
  output logic [PIX_W-1:0] pe_sum_2,
  output logic [PIX_W-1:0] pe_sum_3,
  output logic [PIX_W-1:0] pe_sum_4,
  output logic [PIX_W-1:0] pe_sum_5,
  output logic             pe_sum_valid,
  output logic [CH_W-1:0]  c_i_c,
  output logic             conv_done,
  output logic             conv_done_1,
  output logic             conv_done_2
);

  localparam int GW = cnt_w(GROUPS_PER_CH);
  localparam int WW = cnt_w(DONE2_DLY);
  localparam logic [GW-1:0]   GRP_LAST   = GW'(GROUPS_PER_CH - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [WW-1:0]   WAIT_LAST  = WW'(DONE2_DLY - 1);
  localparam logic [WW-1:0]   DRAIN_LAST = WW'(1);

  conv_state_t       state_q, state_d;
  logic [GW-1:0]     grp_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              accept, last_grp, go_run, fire_d1, fire_d2;
  logic              s1_vld;
  logic [CH_W-1:0]   s1_ch;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign last_grp = accept && (grp_cnt == GRP_LAST) && (ch_cnt == CH_LAST);

  // Next-state and transition strobes.
  always_comb begin
    state_d = state_q;
    go_run  = 1'b0;
    fire_d1 = 1'b0;
    fire_d2 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          go_run  = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_grp) state_d = ST_DRAIN;
      end
      // Two cycles here let the final group reach pe_sum before readout starts.
      ST_DRAIN: begin
        if (wait_cnt == DRAIN_LAST) begin
          state_d = ST_DONE_WAIT;
          fire_d1 = 1'b1;
        end
      end
      ST_DONE_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_d = ST_IDLE;
          fire_d2 = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wait_cnt    <= '0;
      conv_done   <= 1'b0;
      conv_done_1 <= 1'b0;
      conv_done_2 <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_done_1 <= fire_d1;
      conv_done_2 <= fire_d2;
      if (go_run)       conv_done <= 1'b0;
      else if (fire_d1) conv_done <= 1'b1;
      // wait_cnt restarts on every state change and counts cycles spent in
      // DRAIN / DONE_WAIT.
      if (state_d != state_q) wait_cnt <= '0;
      else if (state_q == ST_DRAIN || state_q == ST_DONE_WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Group / channel counters; they hold on the final group so the layer
  // ends with a stable index until the next start clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grp_cnt <= '0;
      ch_cnt  <= '0;
    end else if (go_run) begin
      grp_cnt <= '0;
      ch_cnt  <= '0;
    end else if (accept && !last_grp) begin
      if (grp_cnt == GRP_LAST) begin
        grp_cnt <= '0;
        ch_cnt  <= ch_cnt + 1'b1;
      end else begin
        grp_cnt <= grp_cnt + 1'b1;
      end
    end
  end

  // Valid and channel tag ride alongside the MAC stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld       <= 1'b0;
      s1_ch        <= '0;
      pe_sum_valid <= 1'b0;
      c_i_c        <= '0;
    end else begin
      s1_vld       <= accept;
      pe_sum_valid <= s1_vld;
      if (accept) s1_ch <= ch_cnt;
      if (s1_vld) c_i_c <= s1_ch;
    end
  end

  logic [PIX_W-1:0] pix  [7];
  logic [PIX_W-1:0] sums [5];

  assign pix[0] = ifm_0;
  assign pix[1] = ifm_1;
  assign pix[2] = ifm_2;
  assign pix[3] = ifm_3;
  assign pix[4] = ifm_4;
  assign pix[5] = ifm_5;
  assign pix[6] = ifm_6;

  // MAC g produces pe_sum_(g+1) from the pixel window g..g+2.
  for (genvar g = 0; g < 5; g++) begin : g_mac
    pe_mac3 u_mac (
      .clk    (clk),
      .rstn   (rstn),
      .in_vld (accept),
      .s1_vld (s1_vld),
      .x0     (pix[g]),
      .x1     (pix[g+1]),
      .x2     (pix[g+2]),
      .w0     (w_0),
      .w1     (w_1),
      .w2     (w_2),
      .sum    (sums[g])
    );
  end

  assign pe_sum_1 = sums[0];
  assign pe_sum_2 = sums[1];
  assign pe_sum_3 = sums[2];
  assign pe_sum_4 = sums[3];
  assign pe_sum_5 = sums[4];

endmodule

// File: tb/tb_conv_pe_array.sv
// Bench for conv_pe_array: three instances with different layer geometry.
//   a: NUM_CH=1, GROUPS_PER_CH=1, default DONE2_DLY (arithmetic vectors, done timing)
//   b: NUM_CH=3, GROUPS_PER_CH=4, DONE2_DLY=8 (channel wrap, stalls, ignored start)
//   c: NUM_CH=8, GROUPS_PER_CH=2, DONE2_DLY=4 (reset mid-layer, then full layer)
module tb_conv_pe_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn     [3];
  logic       start    [3];
  logic       in_valid [3];
  logic [7:0] ifm      [7];
  logic [7:0] w        [3];

  logic       in_ready     [3];
  logic       pe_sum_valid [3];
  logic       conv_done    [3];
  logic       conv_done_1  [3];
  logic       conv_done_2  [3];
  logic [5:0] c_i_c        [3];
  logic [7:0] pe_sum       [3][5];

  int total = 0;
  int bad   = 0;

  conv_pe_array #(.NUM_CH(1), .GROUPS_PER_CH(1)) dut_a (
    .clk(clk), .rstn(rstn[0]), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ifm_0(ifm[0]), .ifm_1(ifm[1]), .ifm_2(ifm[2]), .ifm_3(ifm[3]), .ifm_4(ifm[4]),
    .ifm_5(ifm[5]), .ifm_6(ifm[6]), .w_0(w[0]), .w_1(w[1]), .w_2(w[2]),
    .pe_sum_1(pe_sum[0][0]), .pe_sum_2(pe_sum[0][1]), .pe_sum_3(pe_sum[0][2]),
    .pe_sum_4(pe_sum[0][3]), .pe_sum_5(pe_sum[0][4]), .pe_sum_valid(pe_sum_valid[0]),
    .c_i_c(c_i_c[0]), .conv_done(conv_done[0]), .conv_done_1(conv_done_1[0]),
    .conv_done_2(conv_done_2[0]));

  conv_pe_array #(.NUM_CH(3), .GROUPS_PER_CH(4), .DONE2_DLY(8)) dut_b (
    .clk(clk), .rstn(rstn[1]), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ifm_0(ifm[0]), .ifm_1(ifm[1]), .ifm_2(ifm[2]), .ifm_3(ifm[3]), .ifm_4(ifm[4]),
    .ifm_5(ifm[5]), .ifm_6(ifm[6]), .w_0(w[0]), .w_1(w[1]), .w_2(w[2]),
    .pe_sum_1(pe_sum[1][0]), .pe_sum_2(pe_sum[1][1]), .pe_sum_3(pe_sum[1][2]),
    .pe_sum_4(pe_sum[1][3]), .pe_sum_5(pe_sum[1][4]), .pe_sum_valid(pe_sum_valid[1]),
    .c_i_c(c_i_c[1]), .conv_done(conv_done[1]), .conv_done_1(conv_done_1[1]),
    .conv_done_2(conv_done_2[1]));

  conv_pe_array #(.NUM_CH(8), .GROUPS_PER_CH(2), .DONE2_DLY(4)) dut_c (
    .clk(clk), .rstn(rstn[2]), .start(start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ifm_0(ifm[0]), .ifm_1(ifm[1]), .ifm_2(ifm[2]), .ifm_3(ifm[3]), .ifm_4(ifm[4]),
    .ifm_5(ifm[5]), .ifm_6(ifm[6]), .w_0(w[0]), .w_1(w[1]), .w_2(w[2]),
    .pe_sum_1(pe_sum[2][0]), .pe_sum_2(pe_sum[2][1]), .pe_sum_3(pe_sum[2][2]),
    .pe_sum_4(pe_sum[2][3]), .pe_sum_5(pe_sum[2][4]), .pe_sum_valid(pe_sum_valid[2]),
    .c_i_c(c_i_c[2]), .conv_done(conv_done[2]), .conv_done_1(conv_done_1[2]),
    .conv_done_2(conv_done_2[2]));

  typedef struct {
    int x [7];
    int k [3];
    int e [5];
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int x0, input int x1, input int x2, input int x3,
                         input int x4, input int x5, input int x6, input int k0, input int k1,
                         input int k2, input int e1, input int e2, input int e3, input int e4,
                         input int e5);
    vecs[i].x[0] = x0; vecs[i].x[1] = x1; vecs[i].x[2] = x2; vecs[i].x[3] = x3;
    vecs[i].x[4] = x4; vecs[i].x[5] = x5; vecs[i].x[6] = x6;
    vecs[i].k[0] = k0; vecs[i].k[1] = k1; vecs[i].k[2] = k2;
    vecs[i].e[0] = e1; vecs[i].e[1] = e2; vecs[i].e[2] = e3; vecs[i].e[3] = e4;
    vecs[i].e[4] = e5;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nacc, nbeat, nd1, nd2, k;
    bit acc_now, acc_d1;

    // pe_sum_k = ifm_(k-1)*w0 + ifm_k*w1 + ifm_(k+1)*w2, low byte
    set_vec(0,   1,   2,   3,   4,   5,   6,   7,   1,   2,   3,  14,  20,  26,  32,  38);
    set_vec(1, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255,   3,   3,   3,   3,   3);
    set_vec(2,  10,  20,  30,  40,  50,  60,  70,   0,   1,   0,  20,  30,  40,  50,  60);
    set_vec(3, 100,   0, 100,   0, 100,   0, 100,   2,   3,   2, 144,  44, 144,  44, 144);
    set_vec(4,   1,   2,   3,   4,   5,   6,   7,   1,   1,   1,   6,   9,  12,  15,  18);

    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; start[d] = 1'b0; in_valid[d] = 1'b0;
    end
    for (int j = 0; j < 7; j++) ifm[j] = 8'd0;
    for (int j = 0; j < 3; j++) w[j] = 8'd0;

    // Reset state
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_in_ready", d), in_ready[d], 0);
      chk($sformatf("rst%0d_valid", d), pe_sum_valid[d], 0);
      chk($sformatf("rst%0d_done", d), conv_done[d], 0);
      chk($sformatf("rst%0d_done1", d), conv_done_1[d], 0);
      chk($sformatf("rst%0d_done2", d), conv_done_2[d], 0);
      chk($sformatf("rst%0d_cic", d), c_i_c[d], 0);
      chk($sformatf("rst%0d_sum1", d), pe_sum[d][0], 0);
    end
    tick;
    for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
    tick;

    // ---- dut_a: one group per layer, table-driven arithmetic + done timing ----
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 7; j++) ifm[j] = 8'(vecs[i].x[j]);
      for (int j = 0; j < 3; j++) w[j] = 8'(vecs[i].k[j]);
      chk($sformatf("v%0d_done_before_start", i), conv_done[0], (i > 0) ? 1 : 0);
      // start together with in_valid: nothing may be accepted this cycle
      start[0] = 1'b1; in_valid[0] = 1'b1;
      tick;
      start[0] = 1'b0;
      chk($sformatf("v%0d_ready_in_run", i), in_ready[0], 1);
      chk($sformatf("v%0d_done_cleared", i), conv_done[0], 0);
      chk($sformatf("v%0d_no_early_valid", i), pe_sum_valid[0], 0);
      tick;  // group accepted at the edge just passed
      in_valid[0] = 1'b0;
      chk($sformatf("v%0d_valid_t1", i), pe_sum_valid[0], 0);
      chk($sformatf("v%0d_ready_drain", i), in_ready[0], 0);
      tick;
      chk($sformatf("v%0d_valid_t2", i), pe_sum_valid[0], 1);
      chk($sformatf("v%0d_cic", i), c_i_c[0], 0);
      for (int j = 0; j < 5; j++)
        chk($sformatf("v%0d_sum%0d", i, j + 1), pe_sum[0][j], vecs[i].e[j]);
      chk($sformatf("v%0d_done1_t2", i), conv_done_1[0], 0);
      tick;
      chk($sformatf("v%0d_done1_t3", i), conv_done_1[0], 1);
      chk($sformatf("v%0d_done_t3", i), conv_done[0], 1);
      chk($sformatf("v%0d_valid_t3", i), pe_sum_valid[0], 0);
      k = -1;
      for (int n = 1; n <= 3000; n++) begin
        tick;
        if (conv_done_2[0]) begin
          k = n;
          break;
        end
      end
      chk($sformatf("v%0d_done2_delay", i), k, 2048);
      chk($sformatf("v%0d_done_at_done2", i), conv_done[0], 1);
      tick;
      chk($sformatf("v%0d_done2_pulse", i), conv_done_2[0], 0);
    end

    // ---- dut_b: channel wrap with continuous in_valid ----
    start[1] = 1'b1;
    tick;
    start[1] = 1'b0;
    in_valid[1] = 1'b1;
    nacc = 0; nbeat = 0; nd1 = 0; nd2 = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      acc_now = in_ready[1] && in_valid[1];
      if (acc_now) nacc++;
      tick;
      if (acc_now && nacc == 12) chk("wrap_ready_falls", in_ready[1], 0);
      if (pe_sum_valid[1]) begin
        chk($sformatf("wrap_cic_beat%0d", nbeat), c_i_c[1], nbeat / 4);
        nbeat++;
      end
      if (conv_done_1[1]) nd1++;
      if (conv_done_2[1]) nd2++;
    end
    in_valid[1] = 1'b0;
    chk("wrap_accepts", nacc, 12);
    chk("wrap_beats", nbeat, 12);
    chk("wrap_done1_count", nd1, 1);
    chk("wrap_done2_count", nd2, 1);

    // ---- dut_b: stall pattern 1,0,0,1 with start pulses during RUN ----
    chk("stall_done_held", conv_done[1], 1);
    w[0] = 8'd1; w[1] = 8'd0; w[2] = 8'd0;
    start[1] = 1'b1;
    tick;
    start[1] = 1'b0;
    nacc = 0; nbeat = 0; acc_d1 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid[1] = (cyc % 4 == 0) || (cyc % 4 == 3);
      start[1]    = (cyc < 20) && (cyc % 5 == 2);
      ifm[0]      = 8'(nacc);  // each group tagged with its acceptance index
      acc_now     = in_ready[1] && in_valid[1];
      if (acc_now) nacc++;
      tick;
      chk($sformatf("stall_valid_c%0d", cyc), pe_sum_valid[1], acc_d1);
      if (pe_sum_valid[1]) begin
        chk($sformatf("stall_cic_beat%0d", nbeat), c_i_c[1], nbeat / 4);
        chk($sformatf("stall_data_beat%0d", nbeat), pe_sum[1][0], nbeat);
        nbeat++;
      end
      acc_d1 = acc_now;
    end
    start[1] = 1'b0; in_valid[1] = 1'b0;
    chk("stall_accepts", nacc, 12);
    chk("stall_beats", nbeat, 12);

    // ---- dut_c: reset during channel 5, then a full layer ----
    start[2] = 1'b1;
    tick;
    start[2] = 1'b0;
    in_valid[2] = 1'b1;
    nacc = 0;
    for (int n = 0; n < 40 && nacc < 11; n++) begin
      ifm[0] = 8'(nacc);
      if (in_ready[2]) nacc++;
      tick;
    end
    chk("rstmid_reached_ch5", nacc, 11);
    chk("rstmid_busy_before", pe_sum_valid[2], 1);
    rstn[2] = 1'b0;
    #2;
    chk("rstmid_ready", in_ready[2], 0);
    chk("rstmid_valid", pe_sum_valid[2], 0);
    chk("rstmid_cic", c_i_c[2], 0);
    chk("rstmid_done", conv_done[2], 0);
    chk("rstmid_done1", conv_done_1[2], 0);
    chk("rstmid_done2", conv_done_2[2], 0);
    for (int j = 0; j < 5; j++) chk($sformatf("rstmid_sum%0d", j + 1), pe_sum[2][j], 0);
    in_valid[2] = 1'b0;
    tick;
    tick;
    rstn[2] = 1'b1;
    nbeat = 0; nd1 = 0; nd2 = 0;
    for (int n = 0; n < 10; n++) begin
      tick;
      if (pe_sum_valid[2]) nbeat++;
      if (conv_done_1[2]) nd1++;
      if (conv_done_2[2]) nd2++;
    end
    chk("rstmid_no_stale_valid", nbeat, 0);
    chk("rstmid_no_done1", nd1, 0);
    chk("rstmid_no_done2", nd2, 0);

    start[2] = 1'b1;
    tick;
    start[2] = 1'b0;
    in_valid[2] = 1'b1;
    nacc = 0; nbeat = 0; nd1 = 0; nd2 = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      ifm[0]  = 8'(nacc);
      acc_now = in_ready[2] && in_valid[2];
      if (acc_now) nacc++;
      tick;
      if (pe_sum_valid[2]) begin
        chk($sformatf("relayer_cic_beat%0d", nbeat), c_i_c[2], nbeat / 2);
        chk($sformatf("relayer_data_beat%0d", nbeat), pe_sum[2][0], nbeat);
        nbeat++;
      end
      if (conv_done_1[2]) nd1++;
      if (conv_done_2[2]) nd2++;
    end
    in_valid[2] = 1'b0;
    chk("relayer_accepts", nacc, 16);
    chk("relayer_beats", nbeat, 16);
    chk("relayer_done1_count", nd1, 1);
    chk("relayer_done2_count", nd2, 1);
    chk("relayer_done_level", conv_done[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_pe_array.md
CONV_PE_ARRAY -- requirements
Module: conv_pe_array

Interface
REQ-001 Parameter NUM_CH, default 32: input channels per layer, range 1..64.
REQ-002 Parameter GROUPS_PER_CH, default 2048: pixel groups per channel, matching the 2048-word OFM readout.
REQ-003 Parameter DONE2_DLY, default 2048: cycles from conv_done_1 to conv_done_2, aligning tlast with the last output beat when tready is held high.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; starts a layer when idle.
REQ-007 in_valid  in  1  ifm/weight group valid.
REQ-008 in_ready  out  1  block accepts a group this cycle.
REQ-009 ifm_0..ifm_6  in  8 each  seven unsigned IFM pixels.
REQ-010 w_0..w_2  in  8 each  three unsigned weights.
REQ-011 pe_sum_1..pe_sum_5  out  8 each  partial sums to out_buffer.
REQ-012 pe_sum_valid  out  1  pe_sum_* and c_i_c valid.
REQ-013 c_i_c  out  6  channel index of the current pe_sum beat.
REQ-014 conv_done  out  1  level; high from layer completion until the next accepted start.
REQ-015 conv_done_1  out  1  one-cycle pulse; starts OFM readout.
REQ-016 conv_done_2  out  1  one-cycle pulse; produces tlast downstream.

Function
REQ-017 The block SHALL accept a group on in_valid && in_ready; in_ready is 1 only in RUN.
REQ-018 The block SHALL compute pe_sum_k = (ifm_(k-1)*w_0 + ifm_k*w_1 + ifm_(k+1)*w_2) mod 256 for k=1..5, using 16-bit products and a truncated sum.
REQ-019 The pipeline SHALL take 2 cycles: products registered in stage 1, sums registered in stage 2. An accepted group at cycle t appears at pe_sum_valid=1 on cycle t+2.
REQ-020 c_i_c SHALL travel through the pipeline with its data, so it always matches the beat it labels.
REQ-021 A group counter (11 bits at default) SHALL increment per accepted group and wrap to 0 at GROUPS_PER_CH-1. The channel counter SHALL then increment.
REQ-022 FSM states: IDLE, RUN, DRAIN, DONE_WAIT.
- IDLE->RUN on start; clears both counters and conv_done.
- RUN->DRAIN when the last group of channel NUM_CH-1 is accepted.
- DRAIN->DONE_WAIT after 2 cycles (pipeline empty); conv_done_1 pulses on that transition cycle and conv_done goes 1.
- DONE_WAIT->IDLE after DONE2_DLY cycles, pulsing conv_done_2 on the transition cycle.
REQ-023 start outside IDLE SHALL be ignored. Simultaneous start and in_valid in IDLE SHALL NOT accept data that cycle.
REQ-024 in_valid low in RUN SHALL stall counters and insert bubbles (pe_sum_valid=0). No data is lost.
REQ-025 With NUM_CH=1, the first and only channel SHALL carry c_i_c=0 on all beats.

Reset
REQ-026 rstn low SHALL asynchronously force:
- state IDLE; counters 0;
- in_ready, pe_sum_valid, conv_done, conv_done_1, conv_done_2 to 0;
- pe_sum_* and c_i_c to 0.
REQ-027 Reset mid-layer SHALL abort with no done pulses. The pipeline SHALL be emptied (no stale pe_sum_valid after release).

Structure
REQ-028 The shared package conv_pkg SHALL hold the FSM state encoding, the PIX_W=8/PROD_W=16 widths, and the default NUM_CH/GROUPS_PER_CH/DONE2_DLY constants.
REQ-029 One sub-module, pe_mac3, SHALL implement a single 3-tap, 2-stage MAC. It SHALL be instantiated 5 times; the FSM and counters live in conv_pe_array.

Verification
REQ-030 Single group, NUM_CH=1, GROUPS_PER_CH=1: ifm_0..6=1..7, w=1,2,3. Expected: 2 cycles later pe_sum_1..5=14,20,26,32,38 with c_i_c=0. conv_done_1 pulses 3 cycles after acceptance.
REQ-031 Overflow case: all ifm=255, w=255. Expected: every pe_sum = (3*65025) mod 256 = 3.
REQ-032 Channel wrap case: NUM_CH=3, GROUPS_PER_CH=4, continuous in_valid. Expected: 12 beats with c_i_c sequence 0x4,1x4,2x4. in_ready falls after the 12th acceptance.
REQ-033 Stalls: in_valid toggled 1,0,0,1 within a run. Expected: pe_sum_valid mirrors the pattern delayed by 2, counters unchanged during stalls, and start pulses in RUN ignored.
REQ-034 Done timing at defaults: conv_done_2 pulses exactly 2048 cycles after conv_done_1. conv_done stays high until the next start.
REQ-035 Reset mid-layer: rstn pulsed low during channel 5. Expected: all outputs 0 immediately, no conv_done_1/2. A subsequent start runs the full layer correctly.
